// File: rtl/throttle_pkg.sv
// Shared types and default constants for the throttle conditioner.
package throttle_pkg;

  localparam int          TICK_DIV_DEF  = 1024;
  localparam int          AVG_LOG2_DEF  = 2;
  localparam logic [11:0] DEADBAND_DEF  = 12'h080;
  localparam logic [11:0] SLEW_STEP_DEF = 12'h010;

  typedef logic [11:0] cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILT = 2'd1,
    SLEW = 2'd2
  } state_t;

endpackage

// File: rtl/throttle_cond_mov_avg.sv
// Power-of-two moving average: sample shift buffer with a running sum.
module mov_avg
  import throttle_pkg::*;
#(
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  input  cmd_t i_din,
  output cmd_t o_avg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 12 + AVG_LOG2;

  cmd_t          r_buf [DEPTH];
  cmd_t          w_tap_in [DEPTH];
  logic [SW-1:0] r_sum;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
    if (gi == 0) begin : g_head
      assign w_tap_in[gi] = i_din;
    end else begin : g_body
      assign w_tap_in[gi] = r_buf[gi-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= w_tap_in[i];
    end
  end

  // The oldest sample is always contained in the sum, so this cannot underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_load) begin
      r_sum <= r_sum + SW'(i_din) - SW'(r_buf[DEPTH-1]);
    end
  end

  assign o_avg = r_sum[SW-1 -: 12];

endmodule

// File: rtl/throttle_cond.sv
// Throttle conditioner: tick sampling, moving average, deadband, slew-limited drive.
// Define THR_KICKDOWN_EN to drop drv_cmd straight to 0 whenever the target is 0.
module throttle_cond
  import throttle_pkg::*;
#(
  parameter int   TICK_DIV  = TICK_DIV_DEF,
  parameter int   AVG_LOG2  = AVG_LOG2_DEF,
  parameter cmd_t DEADBAND  = DEADBAND_DEF,
  parameter cmd_t SLEW_STEP = SLEW_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] throttle,
  input  logic        en,
  output logic [11:0] drv_cmd,
  output logic        cmd_vld,
  output logic        at_target
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_cnt_last;
  logic          w_tick;

  state_t r_state;
  state_t w_state_next;
  logic   w_load;
  logic   w_do_filt;
  logic   w_do_slew;

  cmd_t        w_avg;
  cmd_t        w_filt_tgt;
  cmd_t        r_target;
  cmd_t        r_drv;
  logic        r_vld;
  logic        r_at;
  logic [12:0] w_up;
  logic [12:0] w_dn;
  cmd_t        w_slew;

  assign w_cnt_last = (r_cnt == CW'(TICK_DIV - 1));
  assign w_tick     = en && w_cnt_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en || w_cnt_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_do_filt    = 1'b0;
    w_do_slew    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_load       = 1'b1;
          w_state_next = FILT;
        end
      end
      FILT: begin
        w_do_filt    = 1'b1;
        w_state_next = SLEW;
      end
      SLEW: begin
        w_do_slew    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (!en) begin
      w_load       = 1'b0;
      w_do_filt    = 1'b0;
      w_do_slew    = 1'b0;
      w_state_next = IDLE;
    end
  end

  mov_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_mov_avg (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!en),
    .i_load(w_load),
    .i_din (throttle),
    .o_avg (w_avg)
  );

  assign w_filt_tgt = (w_avg < DEADBAND) ? '0 : w_avg;

  // 13-bit step values expose carry-out above 0xFFF and borrow below 0x000.
  assign w_up = {1'b0, r_drv} + {1'b0, SLEW_STEP};
  assign w_dn = {1'b0, r_drv} - {1'b0, SLEW_STEP};

  always_comb begin
    w_slew = r_drv;
    if (r_target > r_drv) begin
      w_slew = (w_up > {1'b0, r_target}) ? r_target : w_up[11:0];
    end else if (r_target < r_drv) begin
      w_slew = (w_dn[12] || (w_dn[11:0] < r_target)) ? r_target : w_dn[11:0];
    end
`ifdef THR_KICKDOWN_EN
    if (r_target == '0) begin
      w_slew = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drv    <= '0;
      r_target <= '0;
      r_vld    <= 1'b0;
      r_at     <= 1'b1;
    end else if (!en) begin
      r_drv    <= '0;
      r_target <= '0;
      r_vld    <= 1'b0;
      r_at     <= 1'b1;
    end else begin
      r_vld <= w_do_slew;
      if (w_do_filt) begin
        r_target <= w_filt_tgt;
        r_at     <= (r_drv == w_filt_tgt);
      end
      if (w_do_slew) begin
        r_drv <= w_slew;
        r_at  <= (w_slew == r_target);
      end
    end
  end

  assign drv_cmd   = r_drv;
  assign cmd_vld   = r_vld;
  assign at_target = r_at;

endmodule

// File: tb/tb_throttle_cond.sv
// Directed bench for throttle_cond using a shortened tick period to keep runtime low.
module tb_throttle_cond;
  import throttle_pkg::*;

  localparam int TD = 64;

  logic        clk;
  logic        rst;
  logic [11:0] throttle;
  logic        en;
  logic [11:0] drv_cmd;
  logic        cmd_vld;
  logic        at_target;

  int n_vec;
  int n_err;

  throttle_cond #(
    .TICK_DIV(TD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .throttle (throttle),
    .en       (en),
    .drv_cmd  (drv_cmd),
    .cmd_vld  (cmd_vld),
    .at_target(at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Cycles until cmd_vld is seen, bounded so a dead DUT cannot hang the run.
  task automatic wait_vld(output int n);
    n = 0;
    for (int i = 1; i <= 4 * TD; i++) begin
      step();
      if (cmd_vld) begin
        n = i;
        break;
      end
    end
    if (n == 0) check_val("vld_timeout", 16'd0, 16'd1);
  endtask

  initial begin
    int n;
    int e;
    int ea;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    en       = 1'b1;
    throttle = 12'h07F;
    #2;
    check_val("rst_drv", 16'(drv_cmd), 16'h0000);
    check_val("rst_vld", 16'(cmd_vld), 16'h0000);
    check_val("rst_at", 16'(at_target), 16'h0001);

    // Just below deadband: command stays at 0, one update per tick period.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      wait_vld(n);
      check_val("db_gap", 16'(n), (k == 1) ? 16'(TD + 2) : 16'(TD - 1));
      check_val("db_drv", 16'(drv_cmd), 16'h0000);
      check_val("db_at", 16'(at_target), 16'h0001);
      $display("deadband upd %0d gap=%0d drv=%h at=%b", k, n, drv_cmd, at_target);
      step();
      check_val("db_pulse", 16'(cmd_vld), 16'h0000);
    end

    // Exactly at deadband once the buffer is full of 0x080.
    throttle = 12'h080;
    for (int k = 1; k <= 4; k++) begin
      wait_vld(n);
      check_val("edge_drv", 16'(drv_cmd), (k == 4) ? 16'h0010 : 16'h0000);
      check_val("edge_at", 16'(at_target), (k == 4) ? 16'h0000 : 16'h0001);
      $display("edge upd %0d drv=%h at=%b", k, drv_cmd, at_target);
    end

    // Ramp up to 0x400.
    do_reset();
    throttle = 12'h400;
    for (int k = 1; k <= 67; k++) begin
      wait_vld(n);
      check_val("ramp_drv", 16'(drv_cmd), (k < 64) ? 16'(k * 16) : 16'h0400);
      check_val("ramp_at", 16'(at_target), (k >= 64) ? 16'h0001 : 16'h0000);
      if (k <= 4) check_val("ramp_tgt", 16'(dut.r_target), 16'(k * 256));
      $display("ramp upd %0d drv=%h at=%b", k, drv_cmd, at_target);
    end

    // Ramp down: targets fall 0x300, 0x200, 0x100, then 0.
    throttle = 12'h000;
    for (int k = 1; k <= 8; k++) begin
      wait_vld(n);
`ifdef THR_KICKDOWN_EN
      e  = (k >= 4) ? 0 : 16'h400 - 16 * k;
      ea = (k >= 4) ? 1 : 0;
`else
      e  = 16'h400 - 16 * k;
      ea = 0;
`endif
      check_val("down_drv", 16'(drv_cmd), 16'(e));
      check_val("down_at", 16'(at_target), 16'(ea));
      $display("down upd %0d drv=%h at=%b", k, drv_cmd, at_target);
    end

    // Full scale: saturate at 0xFFF, never wrap.
    do_reset();
    throttle = 12'hFFF;
    for (int k = 1; k <= 300; k++) begin
      wait_vld(n);
      e = (k * 16 > 4095) ? 4095 : k * 16;
      check_val("full_drv", 16'(drv_cmd), 16'(e));
      $display("full upd %0d drv=%h", k, drv_cmd);
    end
    check_val("full_at", 16'(at_target), 16'h0001);

    // Enable drop mid-ramp.
    do_reset();
    throttle = 12'h400;
    for (int k = 1; k <= 5; k++) wait_vld(n);
    check_val("pre_drop_drv", 16'(drv_cmd), 16'h0050);
    for (int i = 0; i < 10; i++) step();
    en = 1'b0;
    step();
    en = 1'b1;
    check_val("drop_drv", 16'(drv_cmd), 16'h0000);
    check_val("drop_at", 16'(at_target), 16'h0001);
    check_val("drop_vld", 16'(cmd_vld), 16'h0000);
    wait_vld(n);
    check_val("restart_gap", 16'(n + 1), 16'(TD + 3));
    check_val("restart_drv", 16'(drv_cmd), 16'h0010);
    $display("restart gap=%0d drv=%h", n + 1, drv_cmd);

    // Asynchronous reset while the FSM sits in SLEW.
    for (int i = 0; i < TD - 1; i++) step();
    check_val("in_slew", 16'(dut.r_state), 16'(SLEW));
    check_val("slew_at_pre", 16'(at_target), 16'h0000);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_drv", 16'(drv_cmd), 16'h0000);
    check_val("arst_vld", 16'(cmd_vld), 16'h0000);
    check_val("arst_at", 16'(at_target), 16'h0001);
    step();
    check_val("arst_hold_vld", 16'(cmd_vld), 16'h0000);
    rst = 1'b0;
    $display("async reset in SLEW drv=%h at=%b", drv_cmd, at_target);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
